// File: rtl/ariane_pkg.sv
// Shared EX-stage definitions: functional-unit operation codes and the
// multiply-operation helpers used by the pipelined multiplier.
package ariane_pkg;

    typedef enum logic [3:0] {
        ADD,
        SUB,
        ANDL,
        ORL,
        XORL,
        SLL,
        SRL,
        SRA,
        MUL,
        MULH,
        MULHU,
        MULHSU,
        MULW
    } fu_op;

    function automatic logic is_mul_op(input fu_op op);
        logic hit;
        hit = 1'b0;
        case (op)
            MUL, MULH, MULHU, MULHSU, MULW: hit = 1'b1;
            default:                        hit = 1'b0;
        endcase
        return hit;
    endfunction

    // Returns {sign_a, sign_b}: which operands are sign-extended before multiplying.
    function automatic logic [1:0] mul_signs(input fu_op op);
        logic [1:0] signs;
        signs = 2'b00;
        case (op)
            MULH:    signs = 2'b11;
            MULHSU:  signs = 2'b10;
            default: signs = 2'b00;
        endcase
        return signs;
    endfunction

endpackage

// File: rtl/mul_pipe_stage.sv
// One valid/ready register slice of the multiplier pipeline, carrying the
// product, operation and transaction tag.
module mul_pipe_stage
    import ariane_pkg::*;
#(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned ID_W   = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              up_valid,
    output logic              up_ready,
    input  logic [DATA_W-1:0] up_prod,
    input  fu_op              up_op,
    input  logic [ID_W-1:0]   up_id,
    output logic              dn_valid,
    input  logic              dn_ready,
    output logic [DATA_W-1:0] dn_prod,
    output fu_op              dn_op,
    output logic [ID_W-1:0]   dn_id
);

    logic              valid_q;
    fu_op              op_q;
    logic [ID_W-1:0]   id_q;
    logic [DATA_W-1:0] prod_q;

    // A slot can take new data when empty or when its content leaves this cycle.
    assign up_ready = !valid_q || dn_ready;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            op_q    <= MUL;
            id_q    <= '0;
            prod_q  <= '0;
        end else begin
            if (flush_i) begin
                valid_q <= 1'b0;
            end else if (up_ready) begin
                valid_q <= up_valid;
            end
            // Payload only moves with a real operation so stalled outputs stay stable.
            if (!flush_i && up_ready && up_valid) begin
                op_q   <= up_op;
                id_q   <= up_id;
                prod_q <= up_prod;
            end
        end
    end

    assign dn_valid = valid_q;
    assign dn_prod  = prod_q;
    assign dn_op    = op_q;
    assign dn_id    = id_q;

endmodule

// File: rtl/mul_pipe.sv
// Fully pipelined RISC-V M-extension multiplier with per-stage valid/ready
// backpressure and flush; results leave strictly in issue order.
module mul_pipe
    import ariane_pkg::*;
#(
    parameter int unsigned XLEN          = 64,
    parameter int unsigned NR_STAGES     = 2,
    parameter int unsigned TRANS_ID_BITS = 3
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  fu_op                     operator_i,
    input  logic [XLEN-1:0]          operand_a_i,
    input  logic [XLEN-1:0]          operand_b_i,
    input  logic [TRANS_ID_BITS-1:0] trans_id_i,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [XLEN-1:0]          result_o,
    output logic [TRANS_ID_BITS-1:0] trans_id_o
);

    localparam int unsigned PROD_W = 2 * XLEN;

    logic [1:0]                signs;
    logic signed [XLEN:0]      a_ext;
    logic signed [XLEN:0]      b_ext;
    logic signed [PROD_W+1:0]  prod_full;
    logic                      unused_prod_msbs;

    // Index k is the input of stage k; index NR_STAGES is the pipe output.
    logic [NR_STAGES:0]        chain_valid;
    logic [NR_STAGES:0]        chain_ready;
    logic [PROD_W-1:0]         chain_prod [NR_STAGES+1];
    fu_op                      chain_op   [NR_STAGES+1];
    logic [TRANS_ID_BITS-1:0]  chain_id   [NR_STAGES+1];

    logic [PROD_W-1:0]         out_prod;
    fu_op                      out_op;

    assign signs     = mul_signs(operator_i);
    assign a_ext     = $signed({signs[1] & operand_a_i[XLEN-1], operand_a_i});
    assign b_ext     = $signed({signs[0] & operand_b_i[XLEN-1], operand_b_i});
    assign prod_full = a_ext * b_ext;
    assign unused_prod_msbs = ^prod_full[PROD_W+1:PROD_W];

    // Non-multiply operators are never captured; flush drops the input outright.
    assign chain_valid[0] = valid_i && is_mul_op(operator_i) && !flush_i;
    assign chain_prod[0]  = prod_full[PROD_W-1:0];
    assign chain_op[0]    = operator_i;
    assign chain_id[0]    = trans_id_i;

    assign ready_o = !flush_i && chain_ready[0];
    assign chain_ready[NR_STAGES] = ready_i;

    for (genvar k = 0; k < NR_STAGES; k++) begin : g_stage
        mul_pipe_stage #(
            .DATA_W (PROD_W),
            .ID_W   (TRANS_ID_BITS)
        ) u_stage (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .flush_i  (flush_i),
            .up_valid (chain_valid[k]),
            .up_ready (chain_ready[k]),
            .up_prod  (chain_prod[k]),
            .up_op    (chain_op[k]),
            .up_id    (chain_id[k]),
            .dn_valid (chain_valid[k+1]),
            .dn_ready (chain_ready[k+1]),
            .dn_prod  (chain_prod[k+1]),
            .dn_op    (chain_op[k+1]),
            .dn_id    (chain_id[k+1])
        );
    end

    assign out_prod   = chain_prod[NR_STAGES];
    assign out_op     = chain_op[NR_STAGES];
    assign valid_o    = chain_valid[NR_STAGES];
    assign trans_id_o = chain_id[NR_STAGES];

    always_comb begin
        result_o = out_prod[XLEN-1:0];
        case (out_op)
            MULH, MULHU, MULHSU: result_o = out_prod[PROD_W-1:XLEN];
            MULW:                result_o = XLEN'($signed(out_prod[31:0]));
            default:             result_o = out_prod[XLEN-1:0];
        endcase
    end

`ifndef SYNTHESIS
    // MULW only exists for RV64; an RV32 core must never issue it here.
    a_no_mulw_rv32 : assert property (@(posedge clk_i) disable iff (rst_i)
        !(XLEN == 32 && valid_i && ready_o && operator_i == MULW));
`endif

endmodule

// File: tb/tb_mul_pipe.sv
// Scoreboard bench for mul_pipe (XLEN=64, NR_STAGES=2) with directed vectors.
module tb_mul_pipe;
    import ariane_pkg::*;

    localparam int unsigned XLEN = 64;
    localparam int unsigned NRS  = 2;
    localparam int unsigned TIDW = 3;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            flush_i;
    logic            valid_i;
    logic            ready_o;
    fu_op            operator_i;
    logic [XLEN-1:0] operand_a_i;
    logic [XLEN-1:0] operand_b_i;
    logic [TIDW-1:0] trans_id_i;
    logic            valid_o;
    logic            ready_i;
    logic [XLEN-1:0] result_o;
    logic [TIDW-1:0] trans_id_o;

    typedef struct {
        logic [TIDW-1:0] id;
        logic [63:0]     res;
        int              acc;
        bit              lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    mul_pipe #(.XLEN(XLEN), .NR_STAGES(NRS), .TRANS_ID_BITS(TIDW)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .operator_i  (operator_i),
        .operand_a_i (operand_a_i),
        .operand_b_i (operand_b_i),
        .trans_id_i  (trans_id_i),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .result_o    (result_o),
        .trans_id_o  (trans_id_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic issue(input fu_op op, input logic [63:0] a, input logic [63:0] b,
                         input logic [TIDW-1:0] id, input logic [63:0] res,
                         input bit push, input bit lat);
        bit   acc;
        exp_t e;
        acc = 1'b0;
        valid_i = 1'b1;
        operator_i = op;
        operand_a_i = a;
        operand_b_i = b;
        trans_id_i = id;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk_i);
            if (ready_o) begin
                acc = 1'b1;
                if (push) begin
                    e.id = id;
                    e.res = res;
                    e.acc = cyc;
                    e.lat = lat;
                    sb.push_back(e);
                end
            end
            @(posedge clk_i);
            #1;
        end
        valid_i = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout tag=%0d actual=not_accepted required=accepted", id);
        end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 30 && sb.size() != 0; i++) @(negedge clk_i);
        check(name, 64'(sb.size()), 64'd0);
        @(posedge clk_i);
        #1;
    endtask

    // Monitor: every delivered result is matched against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (!rst_i && !flush_i && valid_o && ready_i) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result actual_tag=%0d actual=%h required=none",
                             trans_id_o, result_o);
                end else begin
                    e = sb.pop_front();
                    check($sformatf("tag_order_%0d", e.id), 64'(trans_id_o), 64'(e.id));
                    check($sformatf("result_tag_%0d", e.id), result_o, e.res);
                    if (e.lat) check($sformatf("latency_tag_%0d", e.id), 64'(cyc - e.acc), 64'd2);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] hold_res;
        bit          ok;

        rst_i = 1'b1;
        flush_i = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b1;
        operator_i = MUL;
        operand_a_i = '0;
        operand_b_i = '0;
        trans_id_i = '0;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        check("reset_valid_o", 64'(valid_o), 64'd0);
        check("reset_result_o", result_o, 64'd0);
        check("reset_trans_id_o", 64'(trans_id_o), 64'd0);
        check("reset_ready_o", 64'(ready_o), 64'd1);
        @(posedge clk_i);
        #1;

        // Signed / mixed-sign / MULW vectors, issued back-to-back.
        issue(MUL,    ONES, ONES, 3'd1, 64'h1, 1, 1);
        issue(MULH,   ONES, ONES, 3'd2, 64'h0, 1, 1);
        issue(MULHU,  ONES, 64'd2, 3'd3, 64'h1, 1, 1);
        issue(MULHSU, ONES, 64'd2, 3'd4, ONES, 1, 1);
        issue(MULW,   64'h7FFF_FFFF, 64'd2, 3'd5, 64'hFFFF_FFFF_FFFF_FFFE, 1, 1);
        issue(MULW,   64'h1_0000_0003, 64'd3, 3'd6, 64'h9, 1, 1);
        issue(MUL,    64'd3, 64'd5, 3'd7, 64'd15, 1, 1);
        issue(MULH,   64'h8000_0000_0000_0000, 64'd2, 3'd0, ONES, 1, 1);
        issue(MULHU,  64'h8000_0000_0000_0000, 64'd2, 3'd1, 64'h1, 1, 1);
        drain("drain_vectors");

        // Backpressure: two ops fill the pipe, the third must wait.
        ready_i = 1'b0;
        fork
            begin
                issue(MUL, 64'd3,  64'd5,  3'd0, 64'd15,  1, 0);
                issue(MUL, 64'd7,  64'd6,  3'd1, 64'd42,  1, 0);
                issue(MUL, 64'd10, 64'd10, 3'd2, 64'd100, 1, 0);
            end
            begin
                repeat (3) @(negedge clk_i);
                check("bp_ready_low", 64'(ready_o), 64'd0);
                check("bp_valid_held", 64'(valid_o), 64'd1);
                check("bp_head_tag", 64'(trans_id_o), 64'd0);
                hold_res = result_o;
                ok = 1'b1;
                repeat (3) begin
                    @(negedge clk_i);
                    if (!valid_o || trans_id_o != 3'd0 || result_o !== hold_res) ok = 1'b0;
                end
                check("bp_stable", 64'(ok), 64'd1);
                @(posedge clk_i);
                #1;
                ready_i = 1'b1;
            end
        join
        drain("drain_backpressure");

        // Flush squashes tags 4 and 5 and drops the input shown during the flush.
        issue(MUL, 64'd2, 64'd2, 3'd4, 64'd4, 0, 0);
        issue(MUL, 64'd3, 64'd3, 3'd5, 64'd9, 0, 0);
        flush_i = 1'b1;
        valid_i = 1'b1;
        operator_i = MUL;
        operand_a_i = 64'd1;
        operand_b_i = 64'd1;
        trans_id_i = 3'd7;
        @(negedge clk_i);
        check("flush_ready_low", 64'(ready_o), 64'd0);
        @(posedge clk_i);
        #1;
        flush_i = 1'b0;
        issue(MUL, 64'd6, 64'd7, 3'd6, 64'd42, 1, 1);
        drain("drain_flush");

        // Async reset mid-stall, then a non-multiply request.
        ready_i = 1'b0;
        issue(MUL, 64'd5, 64'd5, 3'd1, 64'd25, 0, 0);
        issue(MUL, 64'd6, 64'd6, 3'd2, 64'd36, 0, 0);
        @(negedge clk_i);
        check("pre_reset_valid", 64'(valid_o), 64'd1);
        #2;
        rst_i = 1'b1;
        #1;
        check("async_rst_valid_o", 64'(valid_o), 64'd0);
        check("async_rst_result_o", result_o, 64'd0);
        check("async_rst_trans_id_o", 64'(trans_id_o), 64'd0);
        check("async_rst_ready_o", 64'(ready_o), 64'd1);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        ready_i = 1'b1;
        issue(ADD, 64'd5, 64'd5, 3'd3, 64'd10, 0, 0);
        ok = 1'b1;
        repeat (10) begin
            @(negedge clk_i);
            if (valid_o) ok = 1'b0;
        end
        check("filter_no_valid", 64'(ok), 64'd1);
        check("final_scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_pipe.md
# mul_pipe

Parametrised, fully pipelined integer multiplier for the EX stage. It implements the RISC-V M-extension multiply operations (MUL, MULH, MULHU, MULHSU, MULW) over a configurable XLEN. Latency is configurable, with per-stage valid/ready backpressure and a flush that squashes in-flight operations. It replaces the fixed single-register multiplier path and can stall when the writeback port is busy, without losing or reordering results.

## Interface
- XLEN, default 64: operand/result width; 32 or 64.
- NR_STAGES, default 2: pipeline register stages, ≥1; equals no-stall latency.
- TRANS_ID_BITS, default 3: width of the scoreboard transaction tag.

Clock and reset:
- clk_i  in  1  clock; all state on rising edge.
- rst_i  in  1  asynchronous, active-high reset.

Ports:
- flush_i  in  1  squash all in-flight operations.
- valid_i  in  1  request valid.
- ready_o  out  1  request accepted this cycle when valid_i && ready_o.
- operator_i  in  fu_op  operation; only MUL/MULH/MULHU/MULHSU/MULW are captured.
- operand_a_i, operand_b_i  in  XLEN  rs1, rs2.
- trans_id_i  in  TRANS_ID_BITS  tag, returned with result.
- valid_o  out  1  result valid; held until ready_i.
- ready_i  in  1  writeback accepts result.
- result_o  out  XLEN  result.
- trans_id_o  out  TRANS_ID_BITS  tag of result_o.

## Operation
- Operand signedness: MULH has a and b signed. MULHSU has a signed and b unsigned. MUL, MULHU and MULW are unsigned.
- The product is computed as a 2·XLEN+2-bit signed multiply of sign-extended operands, truncated to 2·XLEN.
- The product is registered at stage 0 together with operator and tag. Stages 1..NR_STAGES-1 only carry data, which is available for synthesis retiming.
- Result select at the output stage:
  - MULH/MULHU/MULHSU return product[2·XLEN-1:XLEN].
  - MULW returns the sign-extended product[31:0].
  - MUL returns product[XLEN-1:0].
- Capture rule: valid_i with an operator outside the multiply set is not captured and creates no result.
- Per-stage state is valid_q[k], op_q[k], id_q[k] and prod_q[k].
- Stage k advances when its downstream slot is free: free[k] = !valid_q[k+1] || advance[k+1]. The last stage advances on ready_i.
- ready_o = !flush_i && (!valid_q[0] || advance[0]).
- Results are delivered strictly in issue order. Capacity is NR_STAGES operations.
- Flush has priority over everything in the same cycle:
  - all valid_q bits clear on the next edge;
  - any input presented that cycle is dropped (ready_o = 0);
  - valid_o stays combinational from valid_q, so a result shown during the flush cycle is not counted as delivered.
- XLEN = 32 with MULW is illegal. An assertion fires; result is undefined.

## Timing
- Reset values: valid_o = 0, result_o = 0, trans_id_o = 0, ready_o = 1 (when flush_i = 0). All valid_q, op_q = MUL, id_q and prod_q are 0.
- Reset is asynchronous: asserting rst_i mid-operation discards all operations immediately.
- No-stall latency: an operation accepted at edge t appears with valid_o = 1 after edge t+NR_STAGES-1, i.e. NR_STAGES cycles from valid_i.
- Throughput is one operation per cycle.
- Stall (ready_i = 0): valid_o, result_o and trans_id_o stay stable. Upstream stages fill bubbles. ready_o falls only when all NR_STAGES slots are full.
- Full-pipe pass-through: with all stages full and ready_i = 1, ready_o = 1 in the same cycle.

## Structure
- Operation set and sign-select function live in ariane_pkg: is_mul_op(fu_op) and mul_signs(fu_op) returning {sign_a, sign_b}.
- One sub-module: mul_pipe_stage, a single valid/ready register slice (data, op, id) instantiated NR_STAGES times with a generate loop.

## Test plan
All scenarios use XLEN = 64 and NR_STAGES = 2.
- **Signed products:** MUL a = b = 0xFFFF_FFFF_FFFF_FFFF → result 0x1. MULH with the same operands → result 0x0. Tags return 1, 2; valid_o rises 2 cycles after each input.
- **Mixed signedness:** MULHU a = all-ones, b = 2 → 0x1. MULHSU a = all-ones, b = 2 → 0xFFFF_FFFF_FFFF_FFFF.
- **MULW:** a = 0x7FFF_FFFF, b = 2 → 0xFFFF_FFFF_FFFF_FFFE. MULW a = 0x1_0000_0003, b = 3 → 0x9.
- **Backpressure:** 3 back-to-back MULs (tags 0, 1, 2), ready_i held low for 5 cycles.
  - ready_o drops with 2 held.
  - The third op waits and is not lost.
  - Results return in tag order 0, 1, 2 once ready_i = 1.
- **Flush:** issue tags 4 and 5 back-to-back, pulse flush_i on the cycle after the second issue.
  - No valid_o for tags 4 or 5.
  - ready_o = 0 during the flush cycle.
  - A MUL issued the following cycle returns normally.
- **Reset and filtering:** assert rst_i mid-stall with 2 held → valid_o = 0 immediately, outputs 0. Then valid_i with ADD → no valid_o ever produced.
